// File: rtl/rr_packet_mux.sv
// Round-robin packet multiplexer: merges NUM_REQ beat streams into one registered output,
// keeping each packet contiguous by locking onto a channel until its last beat.
module rr_packet_mux #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 arst_ni,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
   input  logic [NUM_REQ-1:0]                   req_last_i,
   input  logic [NUM_REQ-1:0]                   req_valid_i,
   output logic [NUM_REQ-1:0]                   req_ready_o,
   output logic [DATA_WIDTH-1:0]                out_data_o,
   output logic                                 out_last_o,
   output logic [SRC_W-1:0]                     out_src_o,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]      lock_idx_q, lock_idx_d;
   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic [SRC_W-1:0]      src_q, src_d;

   logic                  can_load;
   logic                  sel_found;
   logic [SRC_W-1:0]      sel_idx;
   logic [SRC_W-1:0]      scan_idx;
   logic                  accept;
   int                    idx;

   assign can_load = ~full_q | out_ready_i;

   // Channel selection: locked channel only, otherwise first valid from rr_ptr with wrap.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = lock_idx_q;
      scan_idx  = '0;
      idx       = 0;
      if (state_q == ST_LOCKED) begin
         sel_found = req_valid_i[lock_idx_q];
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            scan_idx = SRC_W'(idx);
            if (!sel_found && req_valid_i[scan_idx]) begin
               sel_found = 1'b1;
               sel_idx   = scan_idx;
            end
         end
      end
   end

   // Gating with arst_ni keeps every ready low while reset is held.
   assign accept = arst_ni & sel_found & can_load;

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[sel_idx] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      full_d     = full_q;
      data_d     = data_q;
      last_d     = last_q;
      src_d      = src_q;
      if (accept) begin
         full_d = 1'b1;
         data_d = req_data_i[sel_idx];
         last_d = req_last_i[sel_idx];
         src_d  = sel_idx;
         if (req_last_i[sel_idx]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (sel_idx == SRC_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
         end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = sel_idx;
         end
      end else if (out_ready_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         full_q     <= 1'b0;
         data_q     <= '0;
         last_q     <= 1'b0;
         src_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         full_q     <= full_d;
         data_q     <= data_d;
         last_q     <= last_d;
         src_q      <= src_d;
      end
   end

   assign out_valid_o = full_q;
   assign out_data_o  = data_q;
   assign out_last_o  = last_q;
   assign out_src_o   = src_q;

endmodule

// File: tb/tb_rr_packet_mux.sv
// Directed vector table plus hand-written reset sequence and a randomized scoreboard run
// for rr_packet_mux with four channels.
module tb_rr_packet_mux;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;

   logic                               clk_i = 1'b0;
   logic                               arst_ni;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]                 req_last_i;
   logic [NUM_REQ-1:0]                 req_valid_i;
   logic [NUM_REQ-1:0]                 req_ready_o;
   logic [DATA_WIDTH-1:0]              out_data_o;
   logic                               out_last_o;
   logic [1:0]                         out_src_o;
   logic                               out_valid_o;
   logic                               out_ready_i;

   rr_packet_mux #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk_i       (clk_i),
      .arst_ni     (arst_ni),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .out_src_o   (out_src_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       ordy;
      logic [7:0] tag;
      logic [3:0] exp_rdy;
      logic       exp_vld;
      logic [7:0] exp_data;
      logic       exp_last;
      logic [1:0] exp_src;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   int   seq[NUM_REQ];
   int   oseq[NUM_REQ];
   int   wait_c[NUM_REQ];
   logic [3:0] rv;
   logic [3:0] acc;
   bit   open_pkt;
   int   open_src;
   int   in_beats, out_beats;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] v, input logic [3:0] l, input logic o, input logic [7:0] t,
                      input logic [3:0] er, input logic ev, input logic [7:0] ed, input logic el,
                      input logic [1:0] es);
      vec_t x;
      x.valid = v; x.last = l; x.ordy = o; x.tag = t;
      x.exp_rdy = er; x.exp_vld = ev; x.exp_data = ed; x.exp_last = el; x.exp_src = es;
      vecs.push_back(x);
   endtask

   // Channel i carries tag + 16*i so the source of every beat is visible in its data.
   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic o, input logic [7:0] t);
      for (int i = 0; i < NUM_REQ; i++) req_data_i[i] = t + 8'(16 * i);
      req_valid_i = v;
      req_last_i  = l;
      out_ready_i = o;
   endtask

   function automatic logic last_fn(input int s, input int c);
      return ((s + c) % 3) == 2;
   endfunction

   task automatic check_out();
      int s;
      s = int'(out_src_o);
      chk("rand data", 32'(out_data_o), 32'({2'(s), 6'(oseq[s])}));
      chk("rand last", 32'(out_last_o), 32'(last_fn(oseq[s], s)));
      if (open_pkt) chk("rand interleave", 32'(s), 32'(open_src));
      open_pkt = !out_last_o;
      open_src = s;
      oseq[s]++;
      out_beats++;
   endtask

   initial begin
      arst_ni     = 1'b0;
      req_data_i  = '0;
      req_last_i  = '0;
      req_valid_i = 4'hF;
      out_ready_i = 1'b1;

      // round robin over four single-beat channels
      add(4'hF, 4'hF, 1, 8'h01, 4'b0001, 1, 8'h01, 1, 0);
      add(4'hF, 4'hF, 1, 8'h02, 4'b0010, 1, 8'h12, 1, 1);
      add(4'hF, 4'hF, 1, 8'h03, 4'b0100, 1, 8'h23, 1, 2);
      add(4'hF, 4'hF, 1, 8'h04, 4'b1000, 1, 8'h34, 1, 3);
      add(4'hF, 4'hF, 1, 8'h05, 4'b0001, 1, 8'h05, 1, 0);
      add(4'h0, 4'h0, 1, 8'h06, 4'b0000, 0, 8'h00, 0, 0);
      // three-beat packet on ch1 with ch0/ch2 waiting
      add(4'h7, 4'h0, 1, 8'h07, 4'b0010, 1, 8'h17, 0, 1);
      add(4'h7, 4'h5, 1, 8'h08, 4'b0010, 1, 8'h18, 0, 1);
      add(4'h7, 4'h2, 1, 8'h09, 4'b0010, 1, 8'h19, 1, 1);
      add(4'h5, 4'h5, 1, 8'h0A, 4'b0100, 1, 8'h2A, 1, 2);
      add(4'h1, 4'h1, 1, 8'h0B, 4'b0001, 1, 8'h0B, 1, 0);
      add(4'h0, 4'h0, 1, 8'h0C, 4'b0000, 0, 8'h00, 0, 0);
      // output back-pressure holding 0xA5
      add(4'h2, 4'h2, 0, 8'h95, 4'b0010, 1, 8'hA5, 1, 1);
      for (int i = 0; i < 5; i++) add(4'h6, 4'h6, 0, 8'h30, 4'b0000, 1, 8'hA5, 1, 1);
      add(4'h6, 4'h6, 1, 8'h40, 4'b0100, 1, 8'h60, 1, 2);
      add(4'h6, 4'h6, 1, 8'h51, 4'b0010, 1, 8'h61, 1, 1);
      add(4'h0, 4'h0, 1, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
      // wrap-around ch3 -> ch0, pointer ends at 1
      add(4'h4, 4'h4, 1, 8'h07, 4'b0100, 1, 8'h27, 1, 2);
      add(4'h8, 4'h8, 1, 8'h08, 4'b1000, 1, 8'h38, 1, 3);
      add(4'h1, 4'h1, 1, 8'h09, 4'b0001, 1, 8'h09, 1, 0);
      add(4'h5, 4'h5, 1, 8'h0C, 4'b0100, 1, 8'h2C, 1, 2);
      add(4'h0, 4'h0, 1, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
      // locked channel drops valid: mux stalls despite other requests
      add(4'h1, 4'h0, 1, 8'h70, 4'b0001, 1, 8'h70, 0, 0);
      add(4'h6, 4'h6, 1, 8'h71, 4'b0000, 0, 8'h00, 0, 0);
      add(4'h7, 4'h1, 1, 8'h72, 4'b0001, 1, 8'h72, 1, 0);
      add(4'h6, 4'h6, 1, 8'h73, 4'b0010, 1, 8'h83, 1, 1);
      add(4'h0, 4'h0, 1, 8'h00, 4'b0000, 0, 8'h00, 0, 0);

      #12;
      chk("reset valid", 32'(out_valid_o), 32'(0));
      chk("reset data",  32'(out_data_o),  32'(0));
      chk("reset last",  32'(out_last_o),  32'(0));
      chk("reset src",   32'(out_src_o),   32'(0));
      chk("reset ready", 32'(req_ready_o), 32'(0));
      req_valid_i = '0;
      #1 arst_ni = 1'b1;
      @(posedge clk_i); #1;

      foreach (vecs[k]) begin
         drive(vecs[k].valid, vecs[k].last, vecs[k].ordy, vecs[k].tag);
         #1;
         chk($sformatf("v%0d ready", k), 32'(req_ready_o), 32'(vecs[k].exp_rdy));
         @(posedge clk_i); #1;
         chk($sformatf("v%0d valid", k), 32'(out_valid_o), 32'(vecs[k].exp_vld));
         if (vecs[k].exp_vld) begin
            chk($sformatf("v%0d data", k), 32'(out_data_o), 32'(vecs[k].exp_data));
            chk($sformatf("v%0d last", k), 32'(out_last_o), 32'(vecs[k].exp_last));
            chk($sformatf("v%0d src", k),  32'(out_src_o),  32'(vecs[k].exp_src));
         end
      end

      // asynchronous reset while locked on ch2
      drive(4'h4, 4'h0, 1, 8'h90);
      #1 chk("lock2 ready", 32'(req_ready_o), 32'(4'b0100));
      @(posedge clk_i); #1;
      chk("lock2 data", 32'(out_data_o), 32'(8'hB0));
      chk("lock2 src",  32'(out_src_o),  32'(2));
      drive(4'hF, 4'h0, 1, 8'h91);
      #1 chk("locked ready", 32'(req_ready_o), 32'(4'b0100));
      #2 arst_ni = 1'b0;
      #1;
      chk("arst valid", 32'(out_valid_o), 32'(0));
      chk("arst data",  32'(out_data_o),  32'(0));
      chk("arst last",  32'(out_last_o),  32'(0));
      chk("arst src",   32'(out_src_o),   32'(0));
      chk("arst ready", 32'(req_ready_o), 32'(0));
      @(posedge clk_i); #1;
      chk("arst hold valid", 32'(out_valid_o), 32'(0));
      drive(4'hF, 4'hF, 1, 8'hA0);
      #2 arst_ni = 1'b1;
      #1 chk("post-reset ready", 32'(req_ready_o), 32'(4'b0001));
      @(posedge clk_i); #1;
      chk("post-reset valid", 32'(out_valid_o), 32'(1));
      chk("post-reset src",   32'(out_src_o),   32'(0));
      chk("post-reset data",  32'(out_data_o),  32'(8'hA0));

      // randomized run with per-channel sequence scoreboard
      req_valid_i = '0;
      arst_ni = 1'b0;
      #3 arst_ni = 1'b1;
      @(posedge clk_i); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         seq[i] = 0; oseq[i] = 0; wait_c[i] = 0;
      end
      rv = '0; open_pkt = 0; open_src = 0; in_beats = 0; out_beats = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int c = 0; c < NUM_REQ; c++) begin
            if (!rv[c]) rv[c] = ($urandom_range(0, 1) == 1);
            req_data_i[c] = {2'(c), 6'(seq[c])};
            req_last_i[c] = last_fn(seq[c], c);
         end
         req_valid_i = rv;
         out_ready_i = ($urandom_range(0, 3) != 0);
         #3;
         acc = req_valid_i & req_ready_o;
         chk("rand onehot", 32'($onehot0(req_ready_o)), 32'(1));
         if (out_valid_o && !out_ready_i) chk("rand stall ready", 32'(req_ready_o), 32'(0));
         if (out_valid_o && out_ready_i) check_out();
         for (int c = 0; c < NUM_REQ; c++) begin
            if (acc[c]) begin
               if (req_last_i[c]) begin
                  for (int o = 0; o < NUM_REQ; o++) begin
                     if (o != c && rv[o]) begin
                        wait_c[o]++;
                        chk($sformatf("rand starve ch%0d", o), 32'(wait_c[o] <= NUM_REQ), 32'(1));
                     end
                  end
               end
               wait_c[c] = 0;
               seq[c]++;
               rv[c] = 1'b0;
               in_beats++;
            end
         end
         @(posedge clk_i); #1;
      end
      req_valid_i = '0;
      out_ready_i = 1'b1;
      for (int d = 0; d < 3; d++) begin
         #3;
         if (out_valid_o) check_out();
         @(posedge clk_i); #1;
      end
      chk("rand beat count", 32'(out_beats), 32'(in_beats));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_packet_mux.md
RR_PACKET_MUX -- requirements
Module: rr_packet_mux

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of input channels (legal range 1..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload width per beat.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port arst_ni, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port req_data_i, input, NUM_REQ x DATA_WIDTH, payload of each input channel.
REQ-006 SHALL have port req_last_i, input, NUM_REQ, final-beat-of-packet flag per channel.
REQ-007 SHALL have port req_valid_i, input, NUM_REQ, beat-available flag per channel.
REQ-008 SHALL have port req_ready_o, output, NUM_REQ, beat-accepted flag per channel.
REQ-009 SHALL have port out_data_o, output, DATA_WIDTH, registered payload of the merged stream.
REQ-010 SHALL have port out_last_o, output, 1, registered final-beat flag.
REQ-011 SHALL have port out_src_o, output, max(1,$clog2(NUM_REQ)), registered index of the source channel.
REQ-012 SHALL have port out_valid_o, output, 1, output beat valid.
REQ-013 SHALL have port out_ready_i, input, 1, downstream accept.

Function
REQ-014 SHALL transfer an input beat on channel i in a cycle where req_valid_i[i] and req_ready_o[i] are both 1, and an output beat in a cycle where out_valid_o and out_ready_i are both 1.
REQ-015 SHALL hold a single output register (EMPTY/FULL); can_load = EMPTY or out_ready_i (fill-through, full throughput of one beat per cycle).
REQ-016 SHALL assert at most one req_ready_o bit per cycle, only for the channel selected in REQ-017/018, and only when can_load is 1; req_ready_o is combinational from state, req_valid_i and out_ready_i.
REQ-017 SHALL implement states IDLE and LOCKED; in IDLE, select the first channel with req_valid_i set, scanning from rr_ptr upward with wrap-around modulo NUM_REQ.
REQ-018 SHALL, in LOCKED, select only lock_idx regardless of other requests; other channels get ready 0.
REQ-019 SHALL, on an accepted beat with last=0, go to (or stay in) LOCKED with lock_idx = source channel.
REQ-020 SHALL, on an accepted beat with last=1, go to IDLE and set rr_ptr = (source+1) mod NUM_REQ; a single-beat packet (last=1 in IDLE) does not enter LOCKED.
REQ-021 SHALL leave rr_ptr unchanged on cycles with no accepted input beat; rr_ptr does not advance on mid-packet beats.
REQ-022 SHALL load out_data_o, out_last_o, out_src_o and set FULL on an accepted input beat; data appears at the output one cycle after acceptance (latency 1).
REQ-023 SHALL clear to EMPTY when the output beat is taken and no new input beat is accepted in the same cycle.
REQ-024 SHALL keep out_data_o, out_last_o and out_src_o stable while out_valid_o=1 and out_ready_i=0.
REQ-025 SHALL not drop, duplicate or reorder beats; the beats of a packet are contiguous at the output, with no interleaving of other channels.
REQ-026 SHALL, with NUM_REQ=1, pass channel 0 through with out_src_o=0 and rr_ptr constant 0.
REQ-027 SHALL ignore req_data_i and req_last_i of channels not accepted in a cycle; a valid dropped mid-packet by the locked channel stalls the mux (no timeout).

Reset
REQ-028 SHALL, while arst_ni=0, force state IDLE, rr_ptr=0, lock_idx=0, output register EMPTY, out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0, req_ready_o=0.
REQ-029 SHALL, on reset asserted mid-packet, discard the partial packet and the held output beat; after release, arbitration restarts from channel 0.

Verification
REQ-030 SHALL cover: all four channels valid with single-beat packets, out_ready_i=1 -> out_src_o sequence 0,1,2,3,0, one beat per cycle.
REQ-031 SHALL cover: ch1 sends 3 beats (last on beat 3) while ch0/ch2 are valid -> output src 1,1,1 contiguous, then 2, then 0; rr_ptr=2 after ch1's last beat.
REQ-032 SHALL cover: out_ready_i=0 for 5 cycles with FULL data 0xA5 -> out_data_o stays 0xA5, all req_ready_o=0; on release the next beat follows in consecutive cycles.
REQ-033 SHALL cover: only ch3 valid, rr_ptr=3, then only ch0 valid -> wrap-around grants ch3 then ch0, rr_ptr ends at 1.
REQ-034 SHALL cover: arst_ni pulsed low while LOCKED on ch2 -> all outputs 0 at once (asynchronously), and after release the first grant follows scan order from channel 0.
REQ-035 SHALL cover: random valid/last/out_ready_i for 10k cycles, scoreboarded per channel -> zero loss, reorder or interleaving, and no channel starved beyond NUM_REQ packets.
